cybercobra_mc: RTL and testbench
================================

Name: cybercobra_mc

Overview:
- Parametrised multi-cycle successor of the CYBERcobra single-cycle core.
- Same 32-bit instruction format, now generalised in data width, register count and PC width.
- Adds a handshaked instruction fetch, a valid/ready switch input, a strobed output port and a halt state.
- Sits between an instruction ROM (possibly multi-cycle) and board I/O.

Parameters:
- DATA_W, 32: register/ALU width; legal range 24..64.
- NREGS, 32: implemented registers, 2..32; x0 reads 0, writes ignored.
- PC_W, 32: PC width in bits; byte address, low 2 bits always 0.
- RESET_PC, 0: PC value after reset.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  PC_W  fetch byte address (PC).
- imem_ack_i  in  1  fetch data valid.
- imem_rdata_i  in  32  instruction.
- sw_i  in  16  switch data.
- sw_valid_i  in  1  switch data valid.
- sw_ready_o  out  1  core accepts sw_i.
- out_o  out  DATA_W  output register.
- out_valid_o  out  1  one-cycle strobe on out_o update.
- halted_o  out  1  core halted.
- retired_o  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Clock is clk_i; reset is asynchronous, active-low, on rst_ni.
- Reset values:
  - PC=RESET_PC, state FETCH, IR=0, all registers 0.
  - out_o=0, out_valid_o=0, sw_ready_o=0, halted_o=0, retired_o=0.
  - imem_req_o goes high in the first cycle after reset release.
- Instruction fields: [31] J, [30] B, [29:28] WS, [27:23] ALUOP, [22:18] RA1, [17:13] RA2, [12:5] OFF, [4:0] WA.
- Register addressing: RA/WA >= NREGS reads 0; writes to those addresses are dropped.
- FETCH:
  - imem_req_o=1, imem_addr_o=PC.
  - Holds until imem_ack_i=1, then IR<=imem_rdata_i and the state moves to EXEC.
  - The request must not drop while waiting for the ack.
- EXEC (one cycle), one case applies:
  - J=1 and OFF=0: enter HALT; halted_o=1; PC unchanged. Exit only by reset.
  - J=1: PC+=sext(OFF)*4 (signed offset; new vs. predecessor), then FETCH.
  - B=1: if the ALU flag is set, PC+=sext(OFF)*4, else PC+=4; then FETCH. J takes priority over B.
  - J=B=0, WS=0: rd[WA]<=sext(IR[27:5]) to DATA_W; PC+=4.
  - J=B=0, WS=1: rd[WA]<=ALU result; PC+=4.
  - J=B=0, WS=2: sw_ready_o=1. If sw_valid_i=1 this cycle, rd[WA]<=sext(sw_i), PC+=4 and the state moves to FETCH. Otherwise the state moves to WAIT_IN.
  - J=B=0, WS=3: out_o<=rd[RA1]; out_valid_o=1 the next cycle only; no RF write; PC+=4.
- WAIT_IN:
  - sw_ready_o=1 until sw_valid_i=1.
  - On that cycle: write sext(sw_i), PC+=4, then FETCH.
- PC arithmetic is modulo 2^PC_W; wrap-around is silent.
- ALU operation (operands a=rd[RA1], b=rd[RA2], shift amount = b[log2(DATA_W)-1:0]):
  - ADD 00000, SUB 01000, SLL 00001, SLTS 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111 → result.
  - LTS 11100, LTU 11110, GES 11101, GEU 11111, EQ 11000, NE 11001 → flag.
  - Undefined opcodes → result=0, flag=0.
- Latency:
  - Minimum 2 cycles per instruction (FETCH with same-cycle ack, then EXEC).
  - Each extra cycle of ack or switch-handshake delay adds 1 cycle.
- Reset mid-operation (any state, including during a pending fetch or WAIT_IN): immediate return to reset values; any in-flight ack is ignored.

Optional Feature:
- Macro: CYBERCOBRA_RETIRE_CNT_EN.
- Defined: retired_o increments by 1 in each cycle an instruction completes. This is the EXEC cycle or the WAIT_IN handshake cycle; the halting instruction does not count. The counter wraps at 2^32.
- Undefined: retired_o is tied to 0 and no counter flops exist.

Test Plan:
- Reset, then program "const 5→x1; const -3→x2; ADD x1,x2→x3; OUT x3" with immediate acks -> out_o=2, out_valid_o high exactly 1 cycle, 4 instructions in 8 cycles.
- imem_ack_i delayed 3 cycles on every fetch -> imem_req_o/imem_addr_o stable while waiting; each instruction takes 5 cycles; same results.
- Input instruction into x4 with sw_valid_i raised 4 cycles after EXEC, sw_i=16'h8001 -> sw_ready_o high 5 cycles; x4 (checked via OUT) =32'hFFFF8001.
- Loop "x1=3; x1=x1+(-1) via x2=-1; B NE x1,x0 OFF=-1" -> branch taken twice then falls through; PC decrements correctly; x1=0 at exit.
- J with OFF=0 at PC=0x10 -> halted_o=1, imem_req_o=0 afterwards. Then assert rst_ni=0 during a later pending fetch -> PC=RESET_PC, halted_o=0.
- With CYBERCOBRA_RETIRE_CNT_EN, run the first program then halt -> retired_o=4; without the macro -> retired_o=0 throughout.

Source files
------------

// File: rtl/cybercobra_mc.sv
`default_nettype none
// ============================================================================
// Module   : cybercobra_mc
// Summary  : Parametrised multi-cycle CYBERcobra core. It fetches over a
//            req/ack handshake, reads switches over valid/ready, drives a
//            strobed output register and stops in a halt state.
// Options  : CYBERCOBRA_RETIRE_CNT_EN enables the 32-bit retired-instruction
//            counter. When the macro is undefined, retired_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module cybercobra_mc #(
  parameter int              DATA_W   = 32,
  parameter int              NREGS    = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  input  logic [15:0]       sw_i,
  input  logic              sw_valid_i,
  output logic              sw_ready_o,
  output logic [DATA_W-1:0] out_o,
  output logic              out_valid_o,
  output logic              halted_o,
  output logic [31:0]       retired_o
);

  localparam int SHW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXEC    = 2'd1,
    S_WAIT_IN = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [31:0]         ir_q;
  logic [DATA_W-1:0]   out_q;
  logic                out_valid_q;

  // Instruction fields
  logic                j_w, b_w;
  logic [1:0]          ws_w;
  logic [4:0]          aluop_w, ra1_w, ra2_w, wa_w;
  logic [7:0]          off_w;

  assign j_w     = ir_q[31];
  assign b_w     = ir_q[30];
  assign ws_w    = ir_q[29:28];
  assign aluop_w = ir_q[27:23];
  assign ra1_w   = ir_q[22:18];
  assign ra2_w   = ir_q[17:13];
  assign off_w   = ir_q[12:5];
  assign wa_w    = ir_q[4:0];

  // Register file: one read port per operand, one write port
  logic [DATA_W-1:0]   rf_rd [32];
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;

  // x0 and addresses beyond NREGS have no storage and read as zero
  for (genvar gi = 0; gi < 32; gi++) begin : g_rf
    if (gi == 0 || gi >= NREGS) begin : g_zero
      assign rf_rd[gi] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] reg_q;
      // Register gi captures the write port when it is the target
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          reg_q <= '0;
        end else if (rf_we && (wa_w == 5'(gi))) begin
          reg_q <= rf_wdata;
        end
      end
      assign rf_rd[gi] = reg_q;
    end
  end

  logic [DATA_W-1:0]   op_a, op_b;
  logic [SHW-1:0]      shamt;
  assign op_a  = rf_rd[ra1_w];
  assign op_b  = rf_rd[ra2_w];
  assign shamt = op_b[SHW-1:0];

  logic [DATA_W-1:0]   alu_res;
  logic                alu_flag;
  logic                lts, ltu;
  assign lts = $signed(op_a) < $signed(op_b);
  assign ltu = op_a < op_b;

  // ALU: data ops give a result, compare ops give the branch flag
  always_comb begin
    alu_res  = '0;
    alu_flag = 1'b0;
    case (aluop_w)
      5'b00000: alu_res = op_a + op_b;
      5'b01000: alu_res = op_a - op_b;
      5'b00001: alu_res = op_a << shamt;
      5'b00010: alu_res = {{(DATA_W-1){1'b0}}, lts};
      5'b00011: alu_res = {{(DATA_W-1){1'b0}}, ltu};
      5'b00100: alu_res = op_a ^ op_b;
      5'b00101: alu_res = op_a >> shamt;
      5'b01101: alu_res = $unsigned($signed(op_a) >>> shamt);
      5'b00110: alu_res = op_a | op_b;
      5'b00111: alu_res = op_a & op_b;
      5'b11100: alu_flag = lts;
      5'b11110: alu_flag = ltu;
      5'b11101: alu_flag = ~lts;
      5'b11111: alu_flag = ~ltu;
      5'b11000: alu_flag = (op_a == op_b);
      5'b11001: alu_flag = (op_a != op_b);
      default: begin
        alu_res  = '0;
        alu_flag = 1'b0;
      end
    endcase
  end

  logic [PC_W-1:0]     pc_plus4, pc_target;
  logic [DATA_W-1:0]   imm_ext, sw_ext;
  assign pc_plus4  = pc_q + PC_W'(4);
  assign pc_target = pc_q + {{(PC_W-10){off_w[7]}}, off_w, 2'b00};
  assign imm_ext   = {{(DATA_W-23){ir_q[27]}}, ir_q[27:5]};
  assign sw_ext    = {{(DATA_W-16){sw_i[15]}}, sw_i};

  logic                out_load;
  logic                sw_ready;

  // Next-state, next-PC and register-write decode
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    out_load = 1'b0;
    sw_ready = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ack_i) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (j_w) begin
          if (off_w == 8'd0) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_target;
            state_d = S_FETCH;
          end
        end else if (b_w) begin
          pc_d    = alu_flag ? pc_target : pc_plus4;
          state_d = S_FETCH;
        end else begin
          case (ws_w)
            2'd0: begin
              rf_we    = 1'b1;
              rf_wdata = imm_ext;
              pc_d     = pc_plus4;
              state_d  = S_FETCH;
            end
            2'd1: begin
              rf_we    = 1'b1;
              rf_wdata = alu_res;
              pc_d     = pc_plus4;
              state_d  = S_FETCH;
            end
            2'd2: begin
              sw_ready = 1'b1;
              if (sw_valid_i) begin
                rf_we    = 1'b1;
                rf_wdata = sw_ext;
                pc_d     = pc_plus4;
                state_d  = S_FETCH;
              end else begin
                state_d  = S_WAIT_IN;
              end
            end
            default: begin
              out_load = 1'b1;
              pc_d     = pc_plus4;
              state_d  = S_FETCH;
            end
          endcase
        end
      end
      S_WAIT_IN: begin
        sw_ready = 1'b1;
        if (sw_valid_i) begin
          rf_we    = 1'b1;
          rf_wdata = sw_ext;
          pc_d     = pc_plus4;
          state_d  = S_FETCH;
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // State, PC, instruction register and output port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_load;
      if (state_q == S_FETCH && imem_ack_i) ir_q  <= imem_rdata_i;
      if (out_load)                         out_q <= op_a;
    end
  end

`ifdef CYBERCOBRA_RETIRE_CNT_EN
  logic [31:0] retired_q;
  logic        retire;
  // An instruction completes exactly when EXEC or WAIT_IN hands back to FETCH
  assign retire = (state_q == S_EXEC || state_q == S_WAIT_IN) && (state_d == S_FETCH);

  // Free-running retired-instruction counter, wraps at 2^32
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
    end
  end
  assign retired_o = retired_q;
`else
  assign retired_o = '0;
`endif

  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = pc_q;
  assign sw_ready_o  = sw_ready;
  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign halted_o    = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_cybercobra_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cybercobra_mc
// Summary  : Self-checking bench for cybercobra_mc. An ISA-level model runs
//            each program first, then the bench acts as ROM and switch source
//            and compares fetch addresses, outputs, timing and halt state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cybercobra_mc;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [15:0] sw_i = '0;
  logic        sw_valid_i = 1'b0;
  logic        sw_ready_o;
  logic [31:0] out_o;
  logic        out_valid_o;
  logic        halted_o;
  logic [31:0] retired_o;

  cybercobra_mc #(
    .DATA_W  (32),
    .NREGS   (32),
    .PC_W    (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_rdata_i(imem_rdata_i),
    .sw_i        (sw_i),
    .sw_valid_i  (sw_valid_i),
    .sw_ready_o  (sw_ready_o),
    .out_o       (out_o),
    .out_valid_o (out_valid_o),
    .halted_o    (halted_o),
    .retired_o   (retired_o)
  );

  always #5 clk_i = ~clk_i;

  bit [31:0] rom [64];
  int        n_chk = 0;
  int        n_fail = 0;

  int        ack_delay, sw_delay;
  bit [15:0] sw_val;
  bit [31:0] exp_fetch [$];
  bit [31:0] exp_out [$];
  int        exp_cycles, exp_ret;
  bit [31:0] exp_halt_pc;

  bit [4:0]  alu_ops [11] = '{5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                             5'b00101, 5'b01101, 5'b00110, 5'b00111, 5'b10000};
  bit [4:0]  flg_ops [7]  = '{5'b11100, 5'b11110, 5'b11101, 5'b11111, 5'b11000, 5'b11001, 5'b11010};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction encoders
  function automatic bit [31:0] e_const(input bit [4:0] wa, input bit [22:0] imm);
    return {4'b0000, imm, wa};
  endfunction
  function automatic bit [31:0] e_alu(input bit [4:0] op, input bit [4:0] a, input bit [4:0] b, input bit [4:0] wa);
    return {2'b00, 2'b01, op, a, b, 8'h00, wa};
  endfunction
  function automatic bit [31:0] e_in(input bit [4:0] wa);
    return {2'b00, 2'b10, 23'd0, wa};
  endfunction
  function automatic bit [31:0] e_out(input bit [4:0] a);
    return {2'b00, 2'b11, 5'd0, a, 5'd0, 8'd0, 5'd0};
  endfunction
  function automatic bit [31:0] e_br(input bit [4:0] op, input bit [4:0] a, input bit [4:0] b, input bit [7:0] off);
    return {2'b01, 2'b00, op, a, b, off, 5'd0};
  endfunction
  function automatic bit [31:0] e_jmp(input bit [7:0] off);
    return {2'b10, 2'b00, 15'd0, off, 5'd0};
  endfunction

  // Reference ALU: {flag, result}
  function automatic bit [32:0] alu_ref(input bit [4:0] op, input bit [31:0] a, input bit [31:0] b);
    bit signed [31:0] sa, sb;
    bit [4:0] sh;
    sa = a; sb = b; sh = b[4:0];
    case (op)
      5'b00000: return {1'b0, a + b};
      5'b01000: return {1'b0, a - b};
      5'b00001: return {1'b0, a << sh};
      5'b00010: return {1'b0, 31'd0, sa < sb};
      5'b00011: return {1'b0, 31'd0, a < b};
      5'b00100: return {1'b0, a ^ b};
      5'b00101: return {1'b0, a >> sh};
      5'b01101: return {1'b0, 32'(sa >>> sh)};
      5'b00110: return {1'b0, a | b};
      5'b00111: return {1'b0, a & b};
      5'b11100: return {sa < sb, 32'd0};
      5'b11110: return {a < b, 32'd0};
      5'b11101: return {sa >= sb, 32'd0};
      5'b11111: return {a >= b, 32'd0};
      5'b11000: return {a == b, 32'd0};
      5'b11001: return {a != b, 32'd0};
      default:  return 33'd0;
    endcase
  endfunction

  // Architectural model: walks the program in rom and records what to expect
  task automatic model_run();
    bit [31:0] r [32];
    bit [31:0] pc, ins, soff, wv;
    bit [32:0] ab;
    bit        wr;
    foreach (r[i]) r[i] = '0;
    pc = 32'h0;
    exp_fetch.delete();
    exp_out.delete();
    exp_cycles = 0;
    exp_ret = 0;
    exp_halt_pc = 32'hFFFF_FFFF;
    for (int s = 0; s < 1000; s++) begin
      ins = rom[pc[7:2]];
      exp_fetch.push_back(pc);
      exp_cycles += ack_delay + 2;
      soff = {{22{ins[12]}}, ins[12:5], 2'b00};
      ab = alu_ref(ins[27:23], r[ins[22:18]], r[ins[17:13]]);
      if (ins[31]) begin
        if (ins[12:5] == 8'd0) begin
          exp_halt_pc = pc;
          return;
        end
        pc += soff;
        exp_ret++;
      end else if (ins[30]) begin
        pc += ab[32] ? soff : 32'd4;
        exp_ret++;
      end else begin
        wr = 1'b1;
        wv = '0;
        case (ins[29:28])
          2'd0: wv = {{9{ins[27]}}, ins[27:5]};
          2'd1: wv = ab[31:0];
          2'd2: begin
            wv = {{16{sw_val[15]}}, sw_val};
            exp_cycles += sw_delay;
          end
          default: begin
            exp_out.push_back(r[ins[22:18]]);
            wr = 1'b0;
          end
        endcase
        if (wr && ins[4:0] != 5'd0) r[ins[4:0]] = wv;
        pc += 32'd4;
        exp_ret++;
      end
    end
  endtask

  // Reset, then act as ROM and switch source until the core halts
  task automatic run_prog(input int abort_at);
    int        cyc, fetch_wait, sw_wait, ready_cnt;
    bit [31:0] last_addr, halt_addr;
    model_run();
    rst_ni = 1'b0;
    imem_ack_i = 1'b0;
    sw_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_halted", halted_o, 1'b0);
    check("rst_out", out_o, 32'h0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_sw_ready", sw_ready_o, 1'b0);
    check("rst_retired", retired_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    cyc = 0; fetch_wait = 0; sw_wait = 0; ready_cnt = 0; last_addr = '0;
    while (cyc < 3000) begin
      if (halted_o) break;
      if (cyc == abort_at) begin
        rst_ni = 1'b0;
        imem_ack_i = 1'b1;
        imem_rdata_i = e_jmp(8'd0);
        #1;
        check("abort_addr", imem_addr_o, 32'h0);
        check("abort_halted", halted_o, 1'b0);
        check("abort_out_valid", out_valid_o, 1'b0);
        check("abort_retired", retired_o, 32'h0);
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        return;
      end
      cyc++;
      imem_ack_i = 1'b0;
      sw_valid_i = 1'b0;
      if (imem_req_o) begin
        if (fetch_wait > 0) check("fetch_addr_hold", imem_addr_o, last_addr);
        last_addr = imem_addr_o;
        if (fetch_wait == ack_delay) begin
          if (exp_fetch.size() == 0) check("fetch_extra", 1'b1, 1'b0);
          else check("fetch_addr", imem_addr_o, exp_fetch.pop_front());
          imem_ack_i = 1'b1;
          imem_rdata_i = rom[imem_addr_o[7:2]];
          fetch_wait = 0;
        end else begin
          fetch_wait++;
          imem_rdata_i = $urandom;
        end
      end
      if (sw_ready_o) begin
        ready_cnt++;
        if (sw_wait == sw_delay) begin
          sw_valid_i = 1'b1;
          sw_i = sw_val;
          check("sw_ready_cycles", ready_cnt, sw_delay + 1);
          ready_cnt = 0;
          sw_wait = 0;
        end else begin
          sw_wait++;
          sw_i = 16'($urandom);
        end
      end
      if (out_valid_o) begin
        if (exp_out.size() == 0) check("out_extra", 1'b1, 1'b0);
        else check("out_value", out_o, exp_out.pop_front());
      end
      @(negedge clk_i);
      #1;
    end
    imem_ack_i = 1'b0;
    sw_valid_i = 1'b0;
    check("halt_reached", halted_o, 1'b1);
    check("cycle_count", cyc, exp_cycles);
    check("fetches_left", exp_fetch.size(), 0);
    check("outputs_left", exp_out.size(), 0);
    check("halt_req", imem_req_o, 1'b0);
    check("halt_pc", imem_addr_o, exp_halt_pc);
`ifdef CYBERCOBRA_RETIRE_CNT_EN
    check("retired", retired_o, exp_ret);
`else
    check("retired", retired_o, 32'h0);
`endif
    halt_addr = imem_addr_o;
    repeat (3) @(negedge clk_i);
    #1;
    check("halt_stays", {halted_o, imem_req_o}, 2'b10);
    check("halt_pc_stays", imem_addr_o, halt_addr);
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = '0;
  endtask

  initial begin
    int idx;
    // Program 1: 5 + (-3) -> OUT, immediate acks, then halt at 0x10
    clear_rom();
    rom[0] = e_const(5'd1, 23'd5);
    rom[1] = e_const(5'd2, 23'h7FFFFD);
    rom[2] = e_alu(5'b00000, 5'd1, 5'd2, 5'd3);
    rom[3] = e_out(5'd3);
    rom[4] = e_jmp(8'd0);
    ack_delay = 0; sw_delay = 0; sw_val = '0;
    run_prog(-1);

    // Same program with a 3-cycle fetch latency
    ack_delay = 3;
    run_prog(-1);

    // Switch input with a late valid, then echo it
    clear_rom();
    rom[0] = e_in(5'd4);
    rom[1] = e_out(5'd4);
    rom[2] = e_jmp(8'd0);
    ack_delay = 0; sw_delay = 4; sw_val = 16'h8001;
    run_prog(-1);

    // Countdown loop with a backward branch
    clear_rom();
    rom[0] = e_const(5'd1, 23'd3);
    rom[1] = e_const(5'd2, 23'h7FFFFF);
    rom[2] = e_alu(5'b00000, 5'd1, 5'd2, 5'd1);
    rom[3] = e_br(5'b11001, 5'd1, 5'd0, 8'hFF);
    rom[4] = e_out(5'd1);
    rom[5] = e_jmp(8'd0);
    ack_delay = 1; sw_delay = 0;
    run_prog(-1);

    // Reset while a fetch is still waiting for its ack, then a clean rerun
    clear_rom();
    rom[0] = e_const(5'd1, 23'd5);
    rom[1] = e_const(5'd2, 23'h7FFFFD);
    rom[2] = e_alu(5'b00000, 5'd1, 5'd2, 5'd3);
    rom[3] = e_out(5'd3);
    rom[4] = e_jmp(8'd0);
    ack_delay = 3;
    run_prog(2);
    ack_delay = 1;
    run_prog(-1);

    // Randomised programs
    for (int it = 0; it < 4; it++) begin
      clear_rom();
      idx = 0;
      for (int k = 1; k <= 5; k++) begin
        rom[idx] = e_const(5'(k), 23'($urandom));
        idx++;
      end
      for (int k = 0; k < 8; k++) begin
        rom[idx] = e_alu(alu_ops[$urandom_range(0, 10)], 5'($urandom_range(0, 5)),
                         5'($urandom_range(0, 5)), 5'd6);
        rom[idx+1] = e_out(5'd6);
        idx += 2;
      end
      for (int k = 0; k < 3; k++) begin
        rom[idx] = e_br(flg_ops[$urandom_range(0, 6)], 5'($urandom_range(0, 5)),
                        5'($urandom_range(0, 5)), 8'd2);
        rom[idx+1] = e_out(5'd1);
        rom[idx+2] = e_out(5'd2);
        idx += 3;
      end
      rom[idx]   = e_in(5'd7);
      rom[idx+1] = e_out(5'd7);
      rom[idx+2] = e_jmp(8'd2);
      rom[idx+3] = e_const(5'd7, 23'd0);
      rom[idx+4] = e_out(5'd7);
      rom[idx+5] = e_jmp(8'd0);
      ack_delay = $urandom_range(0, 2);
      sw_delay  = $urandom_range(0, 3);
      sw_val    = 16'($urandom);
      run_prog(-1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
